// File: rtl/fifo_burst_pkg.sv
// Shared FSM state typedef and encodings for the burst reader.
package fifo_burst_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_GAP  = 2'd2
   } fifo_burst_state_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/fifo_burst_timer.sv
// Idle-cycle counter that raises hit once the configured idle time has elapsed.
module fifo_burst_timer
   import fifo_burst_pkg::*;
#(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          count_en,
   input  logic          clear,
   input  logic [TW-1:0] timeout_cfg,
   output logic          hit
);

   logic [TW-1:0] idle_cnt_r;

   // Saturating idle counter; any ineligible cycle or launch restarts it
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_r <= {TW{1'b0}};
      end else if (clear || !count_en) begin
         idle_cnt_r <= {TW{1'b0}};
      end else if (idle_cnt_r != timeout_cfg) begin
         idle_cnt_r <= idle_cnt_r + TW'(1'b1);
      end else begin
         idle_cnt_r <= idle_cnt_r;
      end
   end

   assign hit = count_en && (idle_cnt_r == timeout_cfg);

endmodule

// File: rtl/fifo_burst_rd.sv
// Burst reader that drains a show-ahead FIFO into length-tagged downstream bursts.
// Define FIFO_BURST_TIMEOUT_EN to enable idle-timeout launch of partial bursts.
module fifo_burst_rd
   import fifo_burst_pkg::*;
#(
   parameter int WD    = 8,
   parameter int DP    = 16,
   parameter int AW    = $clog2(DP),
   parameter int BURST = 4,
   parameter int TW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic [TW-1:0] timeout_cfg,
   input  logic          fifo_empty,
   input  logic [AW:0]   fifo_occupancy,
   input  logic [WD-1:0] fifo_rd_data,
   output logic          fifo_rd_en,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [WD-1:0] m_data,
   output logic [AW:0]   m_len,
   output logic          m_first,
   output logic          m_last,
   output logic          busy
);

   localparam logic [AW:0] BURST_LEN = (AW+1)'(BURST);
   localparam logic [AW:0] LEN_ZERO  = {(AW+1){1'b0}};
   localparam logic [AW:0] LEN_ONE   = (AW+1)'(1'b1);
   localparam logic [AW:0] LEN_TWO   = (AW+1)'(2'd2);

   logic [1:0]  state_r;
   logic [AW:0] beat_cnt_r;
   logic [AW:0] m_len_r;
   logic        m_valid_r;
   logic        m_first_r;
   logic        m_last_r;
   logic        flush_pend_r;
   logic        launch_s;
   logic [AW:0] launch_len_s;
   logic        timeout_hit_s;
   logic        handshake_s;
   logic        occ_nz_s;

   assign occ_nz_s    = (fifo_occupancy != LEN_ZERO);
   assign handshake_s = m_valid_r & m_ready;

`ifdef FIFO_BURST_TIMEOUT_EN
   logic timer_en_s;

   assign timer_en_s = (state_r == ST_IDLE) && occ_nz_s && (fifo_occupancy < BURST_LEN) &&
                       !flush_pend_r && (timeout_cfg != {TW{1'b0}});

   fifo_burst_timer #(.TW(TW)) u_timer (
      .clk         (clk),
      .reset       (reset),
      .count_en    (timer_en_s),
      .clear       (launch_s),
      .timeout_cfg (timeout_cfg),
      .hit         (timeout_hit_s)
   );
`else
   logic unused_timeout_cfg_s;

   assign unused_timeout_cfg_s = ^timeout_cfg;
   assign timeout_hit_s        = 1'b0;
`endif

   // Launch decision in IDLE; below BURST the occupancy is already the min
   always_comb begin
      launch_s     = 1'b0;
      launch_len_s = LEN_ZERO;
      if (state_r == ST_IDLE) begin
         if (fifo_occupancy >= BURST_LEN) begin
            launch_s     = 1'b1;
            launch_len_s = BURST_LEN;
         end else if (flush_pend_r && occ_nz_s) begin
            launch_s     = 1'b1;
            launch_len_s = fifo_occupancy;
         end else if (timeout_hit_s && occ_nz_s) begin
            launch_s     = 1'b1;
            launch_len_s = fifo_occupancy;
         end else begin
            launch_s     = 1'b0;
            launch_len_s = LEN_ZERO;
         end
      end else begin
         launch_s     = 1'b0;
         launch_len_s = LEN_ZERO;
      end
   end

   // Sticky flush request; a new pulse wins over a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_pend_r <= 1'b0;
      end else if (flush) begin
         flush_pend_r <= 1'b1;
      end else if ((state_r == ST_IDLE) &&
                   ((launch_s && (launch_len_s == fifo_occupancy)) || !occ_nz_s)) begin
         flush_pend_r <= 1'b0;
      end else begin
         flush_pend_r <= flush_pend_r;
      end
   end

   // Burst FSM with beat counter and first/last flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         m_valid_r  <= 1'b0;
         m_first_r  <= 1'b0;
         m_last_r   <= 1'b0;
         m_len_r    <= LEN_ZERO;
         beat_cnt_r <= LEN_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (launch_s) begin
                  state_r    <= ST_XFER;
                  m_valid_r  <= 1'b1;
                  m_first_r  <= 1'b1;
                  m_last_r   <= (launch_len_s == LEN_ONE);
                  m_len_r    <= launch_len_s;
                  beat_cnt_r <= launch_len_s;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_XFER: begin
               if (handshake_s) begin
                  beat_cnt_r <= beat_cnt_r - LEN_ONE;
                  m_first_r  <= 1'b0;
                  if (beat_cnt_r == LEN_ONE) begin
                     state_r   <= ST_GAP;
                     m_valid_r <= 1'b0;
                     m_last_r  <= 1'b0;
                  end else begin
                     m_last_r <= (beat_cnt_r == LEN_TWO);
                  end
               end else begin
                  state_r <= ST_XFER;
               end
            end
            ST_GAP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r   <= ST_IDLE;
               m_valid_r <= 1'b0;
               m_first_r <= 1'b0;
               m_last_r  <= 1'b0;
            end
         endcase
      end
   end

   // The pop is additionally gated by empty so a corrupted count can never underflow the FIFO
   assign fifo_rd_en = handshake_s & ~fifo_empty;
   assign m_valid    = m_valid_r;
   assign m_data     = m_valid_r ? fifo_rd_data : {WD{1'b0}};
   assign m_len      = m_len_r;
   assign m_first    = m_first_r;
   assign m_last     = m_last_r;
   assign busy       = (state_r != ST_IDLE) | flush_pend_r;

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Directed plus randomized bench for fifo_burst_rd against a queue-based FIFO and beat scoreboard.
module tb_fifo_burst_rd;

   localparam int WD    = 8;
   localparam int DP    = 16;
   localparam int AW    = 4;
   localparam int BURST = 4;
   localparam int TW    = 8;
`ifdef FIFO_BURST_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic [TW-1:0] timeout_cfg = 8'd0;
   logic          fifo_empty = 1'b1;
   logic [AW:0]   fifo_occupancy = 5'd0;
   logic [WD-1:0] fifo_rd_data = 8'd0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [WD-1:0] m_data;
   logic [AW:0]   m_len;
   logic          m_first;
   logic          m_last;
   logic          busy;

   fifo_burst_rd #(.WD(WD), .DP(DP), .AW(AW), .BURST(BURST), .TW(TW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .timeout_cfg(timeout_cfg),
      .fifo_empty(fifo_empty), .fifo_occupancy(fifo_occupancy), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_len(m_len), .m_first(m_first), .m_last(m_last), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [7:0] fq[$];
   logic [7:0] wr_q[$];
   logic [7:0] sb[$];
   int         lens_seen[$];
   int         gaps[$];
   int         pop_cnt = 0;
   int         errors = 0;
   int         checks = 0;

   // Upstream show-ahead FIFO model
   always @(posedge clk) begin
      if (fifo_rd_en === 1'b1) begin
         if (fq.size() > 0) fq.pop_front();
         pop_cnt++;
      end
      while (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
      fifo_occupancy <= (AW+1)'(fq.size());
      fifo_rd_data   <= (fq.size() > 0) ? fq[0] : 8'h00;
      fifo_empty     <= (fq.size() == 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   int         cyc = 0, bidx = 0, cur_len = 0, prev_occ = 0, first_cyc = 0, last_hs = 0;
   bit         in_burst = 1'b0, gap_next = 1'b0, prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic [7:0] dummy;

   task automatic mon();
      cyc++;
      if (gap_next) begin
         chk("gap_valid_low", 32'(m_valid), 32'd0);
         chk("gap_busy", 32'(busy), 32'd1);
         gap_next = 1'b0;
      end
      if (m_valid === 1'b1) begin
         chk("busy_xfer", 32'(busy), 32'd1);
         if (!in_burst) begin
            in_burst = 1'b1;
            bidx     = 0;
            cur_len  = int'(m_len);
            chk("len_rule", 32'(m_len), (prev_occ >= BURST) ? BURST : prev_occ);
            lens_seen.push_back(int'(m_len));
            gaps.push_back(cyc - last_hs);
            first_cyc = cyc;
         end
         chk("len_stable", 32'(m_len), cur_len);
         chk("first", 32'(m_first), 32'(bidx == 0));
         chk("last", 32'(m_last), 32'(bidx == cur_len - 1));
         chk("data", 32'(m_data), (sb.size() > 0) ? 32'(sb[0]) : 32'h1FF);
         if (prev_stall) chk("stall_hold", 32'(m_data), 32'(prev_data));
         chk("rd_en", 32'(fifo_rd_en), 32'(m_ready));
         prev_stall = (m_ready !== 1'b1);
         prev_data  = m_data;
         if (m_ready === 1'b1) begin
            if (sb.size() > 0) dummy = sb.pop_front();
            bidx++;
            if (bidx == cur_len) begin
               in_burst = 1'b0;
               gap_next = 1'b1;
               last_hs  = cyc;
            end
         end
      end else begin
         chk("rd_en_idle", 32'(fifo_rd_en), 32'd0);
         prev_stall = 1'b0;
      end
      prev_occ = int'(fifo_occupancy);
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int n);
      logic [7:0] v;
      for (int i = 0; i < n; i++) begin
         v = 8'($urandom);
         wr_q.push_back(v);
         sb.push_back(v);
      end
   endtask

   task automatic drain(input string tag);
      m_ready = 1'b1;
      flush   = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 80 && (busy !== 1'b0 || fifo_occupancy != 5'd0 || m_valid !== 1'b0); i++) step();
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_occ"}, 32'(fifo_occupancy), 32'd0);
      chk({tag, "_sb"}, sb.size(), 32'd0);
   endtask

   int  p0, vcount, to_gap;
   bit  pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      @(posedge clk); #1;
      repeat (3) step();
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_len", 32'(m_len), 32'd0);
      chk("rst_first_last", 32'({m_first, m_last}), 32'd0);
      reset = 1'b0;
      step();

      // Full burst at full throughput
      lens_seen.delete(); m_ready = 1'b1; push(4);
      repeat (12) step();
      chk("s1_nbursts", lens_seen.size(), 32'd1);
      chk("s1_len", (lens_seen.size() > 0) ? lens_seen[0] : -1, 32'd4);
      chk("s1_span", last_hs - first_cyc, 32'd3);
      chk("s1_busy", 32'(busy), 32'd0);

      // Backpressure pattern
      lens_seen.delete(); m_ready = 1'b0; push(4);
      for (int i = 0; i < 10 && m_valid !== 1'b1; i++) step();
      chk("s2_valid_seen", 32'(m_valid), 32'd1);
      p0 = pop_cnt;
      for (int i = 0; i < 7; i++) begin
         m_ready = pat[i];
         step();
      end
      m_ready = 1'b0;
      repeat (3) step();
      chk("s2_pops", pop_cnt - p0, 32'd4);
      chk("s2_nbursts", lens_seen.size(), 32'd1);

      // Timeout partial burst
      lens_seen.delete(); gaps.delete(); timeout_cfg = 8'd5; m_ready = 1'b1; push(10);
      repeat (45) step();
      chk("s3_nbursts", lens_seen.size(), TO_EN ? 32'd3 : 32'd2);
      chk("s3_len0", (lens_seen.size() > 0) ? lens_seen[0] : -1, 32'd4);
      chk("s3_len1", (lens_seen.size() > 1) ? lens_seen[1] : -1, 32'd4);
      chk("s3_gap_b2b", (gaps.size() > 1) ? gaps[1] : -1, 32'd3);
      to_gap = (gaps.size() > 2) ? gaps[2] : 0;
      chk("s3_to_gap", to_gap, TO_EN ? 32'(int'(timeout_cfg) + 3) : 32'd0);
      chk("s3_left", 32'(fifo_occupancy), TO_EN ? 32'd0 : 32'd2);
      drain("s3_drain");
      chk("s3_len2", (lens_seen.size() > 2) ? lens_seen[2] : -1, 32'd2);

      // Flush with occupancy 6
      lens_seen.delete(); timeout_cfg = 8'd0; m_ready = 1'b1; push(6); flush = 1'b1;
      step();
      flush = 1'b0;
      chk("s4_busy_pend", 32'(busy), 32'd1);
      repeat (25) step();
      chk("s4_nbursts", lens_seen.size(), 32'd2);
      chk("s4_len0", (lens_seen.size() > 0) ? lens_seen[0] : -1, 32'd4);
      chk("s4_len1", (lens_seen.size() > 1) ? lens_seen[1] : -1, 32'd2);
      chk("s4_busy", 32'(busy), 32'd0);
      chk("s4_occ", 32'(fifo_occupancy), 32'd0);

      // Reset during beat 2 of 4
      m_ready = 1'b1; push(4);
      for (int i = 0; i < 10 && !(m_valid === 1'b1 && bidx == 1); i++) step();
      chk("s5_beat2", 32'(bidx), 32'd1);
      reset = 1'b1; m_ready = 1'b0;
      step();
      reset = 1'b0; m_ready = 1'b1;
      in_burst = 1'b0; bidx = 0; gap_next = 1'b0; prev_stall = 1'b0;
      chk("s5_valid", 32'(m_valid), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_len", 32'(m_len), 32'd0);
      chk("s5_rd_en", 32'(fifo_rd_en), 32'd0);
      p0 = pop_cnt;
      repeat (5) step();
      chk("s5_no_pops", pop_cnt - p0, 32'd0);
      chk("s5_occ", 32'(fifo_occupancy), 32'd3);
      drain("s5_drain");

      // Timeout disabled holds a partial burst
      timeout_cfg = 8'd0; m_ready = 1'b1; push(3); vcount = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (m_valid !== 1'b0) vcount++;
      end
      chk("s6_no_valid", vcount, 32'd0);
      chk("s6_occ", 32'(fifo_occupancy), 32'd3);
      drain("s6_drain");

      // Randomized traffic, backpressure and flushes
      timeout_cfg = 8'd3;
      for (int i = 0; i < 300; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         flush   = ($urandom_range(0, 15) == 0);
         if (fq.size() + wr_q.size() <= DP - 3) push(int'($urandom_range(0, 3)));
         step();
      end
      flush = 1'b0;
      drain("rnd_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
